spi_rx_burst_buffer: RTL and testbench

//  Downstream consumer of the SPI byte interface read path. Requests bytes by driving RDY_OUT.

---
 rtl/spi_rx_burst_buffer.sv | 170 +++++++++++++++++
 tb/tb_spi_rx_burst_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_burst_buffer.sv
// SPI read-path burst consumer: requests bytes over RDY, captures on WE_OUT_N rise, buffers in a show-ahead FIFO.
// Optional per-byte request timeout enabled by defining SPI_RX_TIMEOUT_EN.
module spi_rx_burst_buffer #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned LEN_W      = 8
`ifdef SPI_RX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    input  logic [7:0]        spi_dout,
    input  logic              spi_we_out_n,
    output logic              spi_rdy_out,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_en,
    output logic [ADDR_W:0]   fifo_count,
    output logic              err_timeout
);
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, RELEASE, FINISH} state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   remain, remain_n;
    logic               busy_n, done_n, rdy_n;
    logic               we_d, rise;
    logic               push, pop, room_n;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
    logic [CNT_W-1:0]   count_n;
    logic [7:0]         head_n;

`ifdef SPI_RX_TIMEOUT_EN
    localparam int unsigned TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0]    tcnt, tcnt_n;
    logic               err_n;
`endif

    assign rise     = spi_we_out_n & ~we_d;
    assign pop      = rd_en & rd_valid;
    assign count_n  = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_n = rd_ptr + ADDR_W'(pop);
    assign room_n   = (count_n < CNT_W'(FIFO_DEPTH));
    // A byte pushed into an otherwise-empty FIFO becomes the head immediately.
    assign head_n   = (push && (wr_ptr == rd_ptr_n)) ? spi_dout : mem[rd_ptr_n];

    always_comb begin
        state_n  = state;
        remain_n = remain;
        busy_n   = busy;
        done_n   = 1'b0;
        rdy_n    = 1'b0;
        push     = 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
        err_n    = err_timeout;
        tcnt_n   = tcnt;
`endif
        case (state)
            IDLE: begin
                if (start && (len != '0)) begin
                    state_n  = REQ;
                    remain_n = len;
                    busy_n   = 1'b1;
                    rdy_n    = room_n;
`ifdef SPI_RX_TIMEOUT_EN
                    err_n    = 1'b0;
                    tcnt_n   = '0;
`endif
                end
            end
            REQ: begin
                // RDY drops on the capture edge so the interface never sees a second request.
                if (rise) begin
                    push     = 1'b1;
                    remain_n = remain - LEN_W'(1);
                    state_n  = RELEASE;
                end
`ifdef SPI_RX_TIMEOUT_EN
                else if (spi_rdy_out && (tcnt == TC_W'(TIMEOUT_CYCLES - 1))) begin
                    err_n   = 1'b1;
                    state_n = FINISH;
                end else begin
                    tcnt_n = tcnt + TC_W'(spi_rdy_out);
                    rdy_n  = room_n;
                end
`else
                else begin
                    rdy_n = room_n;
                end
`endif
            end
            RELEASE: begin
                if (!spi_we_out_n) begin
                    if (remain != '0) begin
                        state_n = REQ;
                        rdy_n   = room_n;
`ifdef SPI_RX_TIMEOUT_EN
                        tcnt_n  = '0;
`endif
                    end else begin
                        state_n = FINISH;
                    end
                end
            end
            FINISH: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            remain      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            spi_rdy_out <= 1'b0;
            we_d        <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= 8'h00;
        end else begin
            state       <= state_n;
            remain      <= remain_n;
            busy        <= busy_n;
            done        <= done_n;
            spi_rdy_out <= rdy_n;
            we_d        <= spi_we_out_n;
            wr_ptr      <= wr_ptr + ADDR_W'(push);
            rd_ptr      <= rd_ptr_n;
            fifo_count  <= count_n;
            rd_valid    <= (count_n != '0);
            rd_data     <= (count_n != '0) ? head_n : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= spi_dout;
        end
    end

`ifdef SPI_RX_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            tcnt        <= tcnt_n;
            err_timeout <= err_n;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_spi_rx_burst_buffer.sv
// Bench for spi_rx_burst_buffer: table of burst vectors plus hand sequences; SPI interface modelled behaviourally.
module tb_spi_rx_burst_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       busy, done, spi_rdy_out, rd_valid, err_timeout;
    logic [7:0] spi_dout = 8'h00;
    logic       spi_we_out_n = 1'b0;
    logic [7:0] rd_data;
    logic       rd_en = 1'b0;
    logic [4:0] fifo_count;

    int errors = 0;
    int checks = 0;
    int spi_reads = 0;
    int rdy_pulses = 0;
    int dones = 0;
    logic rdy_prev = 1'b0;
    bit spi_en = 1'b1;
    logic [7:0] gen = 8'h10;
    logic [7:0] spi_q[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef SPI_RX_TIMEOUT_EN
    spi_rx_burst_buffer #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .spi_dout(spi_dout), .spi_we_out_n(spi_we_out_n), .spi_rdy_out(spi_rdy_out),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_en(rd_en),
        .fifo_count(fifo_count), .err_timeout(err_timeout)
    );
`else
    spi_rx_burst_buffer dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
        .spi_dout(spi_dout), .spi_we_out_n(spi_we_out_n), .spi_rdy_out(spi_rdy_out),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_en(rd_en),
        .fifo_count(fifo_count), .err_timeout(err_timeout)
    );
`endif

    // SPI byte interface: answers a high RDY with one byte after a short latency.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (spi_en && spi_rdy_out) begin
                repeat (2) @(negedge clk);
                if (spi_q.size() != 0) b = spi_q.pop_front();
                else begin
                    b = gen;
                    gen = gen + 8'd7;
                end
                spi_dout = b;
                spi_we_out_n = 1'b1;
                exp_q.push_back(b);
                spi_reads++;
                repeat (2) @(negedge clk);
                spi_we_out_n = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (spi_rdy_out && !rdy_prev) rdy_pulses++;
        rdy_prev = spi_rdy_out;
        if (done) dones++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        exp_q.delete();
        spi_q.delete();
        spi_reads = 0;
        rdy_pulses = 0;
        dones = 0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len = 8'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Compares the head against the scoreboard and pops it; called on a negedge.
    task automatic pop_one(input string nm);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got valid=%0d data=%0h", nm, rd_valid, rd_data);
        end else begin
            e = exp_q.pop_front();
            chk(nm, 32'({rd_valid, rd_data}), 32'({1'b1, e}));
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    typedef struct {
        int len;
        int exp_count;
        int exp_reads;
        int exp_dones;
        int exp_busy;
    } vec_t;

    initial begin
        vec_t vecs[5];
        int   n;
        bit   hit;
        bit   prev;

        vecs[0] = '{len: 3,  exp_count: 3,  exp_reads: 3,  exp_dones: 1, exp_busy: 0};
        vecs[1] = '{len: 1,  exp_count: 1,  exp_reads: 1,  exp_dones: 1, exp_busy: 0};
        vecs[2] = '{len: 16, exp_count: 16, exp_reads: 16, exp_dones: 1, exp_busy: 0};
        vecs[3] = '{len: 0,  exp_count: 0,  exp_reads: 0,  exp_dones: 0, exp_busy: 0};
        vecs[4] = '{len: 20, exp_count: 16, exp_reads: 16, exp_dones: 0, exp_busy: 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 32'({busy, done, spi_rdy_out, rd_valid, err_timeout, rd_data, fifo_count}), 0);
        do_reset(2);
        chk("post_reset_outputs", 32'({busy, done, spi_rdy_out, rd_valid, err_timeout, rd_data, fifo_count}), 0);

        // Table-driven bursts
        for (int i = 0; i < 5; i++) begin
            do_reset(10);
            do_start(vecs[i].len);
            repeat (250) @(negedge clk);
            chk($sformatf("vec%0d_count", i), 32'(fifo_count), vecs[i].exp_count);
            chk($sformatf("vec%0d_reads", i), spi_reads, vecs[i].exp_reads);
            chk($sformatf("vec%0d_dones", i), dones, vecs[i].exp_dones);
            chk($sformatf("vec%0d_busy", i), 32'(busy), vecs[i].exp_busy);
            chk($sformatf("vec%0d_rdy", i), 32'(spi_rdy_out), 0);
            for (int k = 0; k < vecs[i].exp_count; k++) pop_one($sformatf("vec%0d_data%0d", i, k));
        end

        // Fixed bytes A5,5A,3C
        do_reset(10);
        spi_q.push_back(8'hA5);
        spi_q.push_back(8'h5A);
        spi_q.push_back(8'h3C);
        do_start(3);
        repeat (100) @(negedge clk);
        chk("len3_rdy_pulses", rdy_pulses, 3);
        chk("len3_dones", dones, 1);
        chk("len3_busy", 32'(busy), 0);
        chk("len3_head", 32'(rd_data), 32'h A5);
        pop_one("len3_b0");
        chk("len3_next", 32'(rd_data), 32'h5A);
        pop_one("len3_b1");
        chk("len3_last", 32'(rd_data), 32'h3C);
        pop_one("len3_b2");
        chk("len3_empty", 32'({rd_valid, fifo_count}), 0);

        // Full FIFO throttling, then one pop releases exactly one read
        do_reset(10);
        do_start(20);
        repeat (250) @(negedge clk);
        chk("full_count", 32'(fifo_count), 16);
        chk("full_rdy_low", 32'(spi_rdy_out), 0);
        pop_one("full_pop");
        repeat (40) @(negedge clk);
        chk("full_reads_after_pop", spi_reads, 17);
        chk("full_count_after_pop", 32'(fifo_count), 16);
        chk("full_rdy_low_again", 32'(spi_rdy_out), 0);

        // Pop on the push cycle with 5 bytes held
        do_reset(10);
        do_start(8);
        hit = 1'b0;
        prev = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (spi_we_out_n && !prev && fifo_count == 5'd5) begin
                hit = 1'b1;
                chk("simul_head", 32'(rd_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
                chk("simul_count", 32'(fifo_count), 5);
            end
            prev = spi_we_out_n;
        end
        chk("simul_reached", 32'(hit), 1);
        repeat (100) @(negedge clk);
        chk("simul_final_count", 32'(fifo_count), 7);
        for (int k = 0; k < 7; k++) pop_one($sformatf("simul_data%0d", k));

        // START while busy is ignored
        do_reset(10);
        do_start(3);
        repeat (4) @(negedge clk);
        do_start(10);
        repeat (150) @(negedge clk);
        chk("busy_start_reads", spi_reads, 3);
        chk("busy_start_dones", dones, 1);
        chk("busy_start_count", 32'(fifo_count), 3);

        // Reset mid-burst
        do_reset(10);
        do_start(8);
        n = 0;
        while (fifo_count < 5'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_reached", 32'(fifo_count >= 5'd2), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", 32'({busy, done, spi_rdy_out, rd_valid, rd_data, fifo_count}), 0);
        repeat (10) @(negedge clk);
        exp_q.delete();
        spi_reads = 0;
        dones = 0;
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("midrst_no_done", dones, 0);
        chk("midrst_no_reads", spi_reads, 0);
        chk("midrst_count", 32'(fifo_count), 0);

`ifdef SPI_RX_TIMEOUT_EN
        // Timeout with the interface never answering
        do_reset(10);
        spi_en = 1'b0;
        do_start(2);
        n = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (err_timeout) break;
            if (spi_rdy_out) n++;
        end
        chk("to_err", 32'(err_timeout), 1);
        chk("to_rdy", 32'(spi_rdy_out), 0);
        chk("to_rdy_cycles", n, 64);
        repeat (4) @(negedge clk);
        chk("to_done", dones, 1);
        chk("to_busy", 32'(busy), 0);
        spi_en = 1'b1;
        do_start(1);
        chk("to_err_cleared", 32'(err_timeout), 0);
        repeat (50) @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
